// File: rtl/fp_compare_pipe.sv
// ============================================================================
// Module   : fp_compare_pipe
// Purpose  : Pipelined IEEE-754 style floating-point comparator. Evaluates
//            FEQ / FLT / FLE (and optionally FMIN / FMAX) combinationally on
//            the accepted operands, then carries the result through STAGES
//            valid/ready pipeline registers with full backpressure support.
// Config   : define FP_CMP_MINMAX_EN to build the FMIN / FMAX datapath;
//            without it OP_SEL 100/101 behave as reserved codes.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - synchronous active-low reset
//            in_valid   - operands and op_sel valid this cycle
//            in_ready   - operation accepted this cycle (when in_valid)
//            op_a/op_b  - operands {sign, exp, man}
//            op_sel     - 000 FEQ, 001 FLT, 010 FLE, 100 FMIN, 101 FMAX
//            out_valid  - r / flag_nv hold a completed result
//            out_ready  - consumer takes the result this cycle
//            r          - 0/1 compare result (zero-extended) or min/max value
//            flag_nv    - invalid-operation flag for the result on r
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_compare_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2     // legal range 1..4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     op_a,
  input  logic [EXP_W+MAN_W:0]     op_b,
  input  logic [2:0]               op_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     r,
  output logic                     flag_nv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int DW = W + 1;                 // {flag_nv, r}

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b100;
  localparam logic [2:0] OP_FMAX = 3'b101;

  // --------------------------------------------------------------------------
  // Operand classification
  // --------------------------------------------------------------------------
  logic             a_sign, b_sign;
  logic [W-2:0]     a_mag, b_mag;
  logic             a_nan, b_nan, a_snan, b_snan;
  logic             any_nan, any_snan, both_zero;

  assign a_sign = op_a[W-1];
  assign b_sign = op_b[W-1];
  assign a_mag  = op_a[W-2:0];
  assign b_mag  = op_b[W-2:0];

  assign a_nan  = (&op_a[W-2:MAN_W]) && (|op_a[MAN_W-1:0]);
  assign b_nan  = (&op_b[W-2:MAN_W]) && (|op_b[MAN_W-1:0]);
  assign a_snan = a_nan && !op_a[MAN_W-1];
  assign b_snan = b_nan && !op_b[MAN_W-1];

  assign any_nan   = a_nan || b_nan;
  assign any_snan  = a_snan || b_snan;
  assign both_zero = (~|a_mag) && (~|b_mag);

  // --------------------------------------------------------------------------
  // Ordered relations (NaN handled by the caller). +0 and -0 are equal here.
  // --------------------------------------------------------------------------
  logic cmp_eq, cmp_lt;

  assign cmp_eq = both_zero || (op_a == op_b);

  always_comb begin
    cmp_lt = 1'b0;
    if (both_zero) begin
      cmp_lt = 1'b0;
    end else if (a_sign != b_sign) begin
      cmp_lt = a_sign;
    end else if (a_sign) begin
      // Both negative: larger magnitude is the smaller value.
      cmp_lt = (a_mag > b_mag);
    end else begin
      cmp_lt = (a_mag < b_mag);
    end
  end

`ifdef FP_CMP_MINMAX_EN
  // --------------------------------------------------------------------------
  // Min/max ordering: like cmp_lt but -0 sorts strictly below +0.
  // --------------------------------------------------------------------------
  logic         tot_lt;
  logic [W-1:0] canon_qnan;

  assign tot_lt     = (a_sign != b_sign) ? a_sign
                    : (a_sign ? (a_mag > b_mag) : (a_mag < b_mag));
  assign canon_qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`endif

  // --------------------------------------------------------------------------
  // Result selection
  // --------------------------------------------------------------------------
  logic [W-1:0] res_r;
  logic         res_nv;

  always_comb begin
    res_r  = '0;
    res_nv = 1'b0;
    case (op_sel)
      OP_FEQ: begin
        res_r  = {{(W-1){1'b0}}, (!any_nan && cmp_eq)};
        res_nv = any_snan;            // quiet NaNs do not signal on equality
      end
      OP_FLT: begin
        res_r  = {{(W-1){1'b0}}, (!any_nan && cmp_lt)};
        res_nv = any_nan;
      end
      OP_FLE: begin
        res_r  = {{(W-1){1'b0}}, (!any_nan && (cmp_lt || cmp_eq))};
        res_nv = any_nan;
      end
`ifdef FP_CMP_MINMAX_EN
      OP_FMIN, OP_FMAX: begin
        res_nv = any_snan;
        if (a_nan && b_nan) begin
          res_r = canon_qnan;
        end else if (a_nan) begin
          res_r = op_b;
        end else if (b_nan) begin
          res_r = op_a;
        end else if (op_sel == OP_FMIN) begin
          res_r = tot_lt ? op_a : op_b;
        end else begin
          res_r = tot_lt ? op_b : op_a;
        end
      end
`endif
      default: begin
        res_r  = '0;
        res_nv = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline: stage 0 takes new operations, stage STAGES-1 drives the outputs.
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] vld;
  logic [DW-1:0]     dat [STAGES];
  logic [STAGES-1:0] adv;

  // A stage may load when some stage at or below it is empty, or the output
  // is being consumed; written without a ripple chain so each bit depends
  // only on the valid bits and out_ready.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_adv
      assign adv[gi] = out_ready || !(&vld[STAGES-1:gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dat[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        dat[0] <= {res_nv, res_r};
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign in_ready  = rst_n && adv[0];
  assign out_valid = vld[STAGES-1];
  assign r         = dat[STAGES-1][W-1:0];
  assign flag_nv   = dat[STAGES-1][W];

endmodule

`default_nettype wire

// File: tb/tb_fp_compare_pipe.sv
// ============================================================================
// Module   : tb_fp_compare_pipe
// Purpose  : Scoreboard bench for fp_compare_pipe (EXP_W=8, MAN_W=23,
//            STAGES=2). Stimulus pushes expected results into a queue; an
//            independent monitor pops and compares on every output handshake.
//            Define FP_CMP_MINMAX_EN to exercise FMIN / FMAX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_compare_pipe;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int STAGES = 2;
  localparam int W      = 1 + EXP_W + MAN_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [2:0]    op_sel = 3'b000;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  r;
  logic          flag_nv;

  fp_compare_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sel    (op_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .flag_nv   (flag_nv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] er;
    logic        env;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   force_stall = 1'b0;
  bit   random_bp   = 1'b0;

  logic [31:0] specials [12] = '{
    32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
    32'h7FC00000, 32'h7F800001, 32'hFFC00001, 32'h3F800000,
    32'hBF800000, 32'h00000001, 32'h80000001, 32'h7F7FFFFF
  };

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (force_stall)    out_ready = 1'b0;
      else if (random_bp) out_ready = ($urandom_range(0, 3) != 0);
      else                out_ready = 1'b1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (value-level) ----------------
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  // Signed numeric rank of a non-NaN value; -0 and +0 share rank 0.
  function automatic longint rank(input logic [31:0] x);
    longint m;
    m = longint'({33'd0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  // Like rank but places -0 just below +0.
  function automatic longint rank_tot(input logic [31:0] x);
    longint m;
    m = longint'({33'd0, x[30:0]});
    return x[31] ? (-m - 1) : m;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op,
                                output logic [31:0] er, output logic env);
    bit na, nb, sa, sb;
    na = is_nan(a);  nb = is_nan(b);
    sa = is_snan(a); sb = is_snan(b);
    er  = 32'd0;
    env = 1'b0;
    case (op)
      3'b000: begin er = {31'd0, (!na && !nb && rank(a) == rank(b))};  env = sa || sb; end
      3'b001: begin er = {31'd0, (!na && !nb && rank(a) <  rank(b))};  env = na || nb; end
      3'b010: begin er = {31'd0, (!na && !nb && rank(a) <= rank(b))};  env = na || nb; end
`ifdef FP_CMP_MINMAX_EN
      3'b100, 3'b101: begin
        env = sa || sb;
        if (na && nb)      er = 32'h7FC00000;
        else if (na)       er = b;
        else if (nb)       er = a;
        else if (op == 3'b100) er = (rank_tot(a) <= rank_tot(b)) ? a : b;
        else                   er = (rank_tot(a) >= rank_tot(b)) ? a : b;
      end
`endif
      default: begin er = 32'd0; env = 1'b0; end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0, 1:    v = specials[$urandom_range(0, 11)];
      2:       v = $urandom;
      default: v = ($urandom & 32'h807FFFFF) | 32'h7F800000;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] er, input logic env, input bit lat);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sel   = op;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) sbq.push_back('{er, env, cyc, lat});
  endtask

  task automatic send_rand();
    logic [31:0] a, b, er;
    logic [2:0]  op;
    logic        env;
    a = rand_operand();
    case ($urandom_range(0, 7))
      0, 1:    b = a;
      2:       b = a ^ 32'h80000000;
      default: b = rand_operand();
    endcase
    op = 3'($urandom_range(0, 7));
    model(a, b, op, er, env);
    send(a, b, op, er, env, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check(name, sbq.size(), 0);
  endtask

  // ---------------- monitor ----------------
  bit          held = 1'b0;
  logic [31:0] hr;
  logic        hnv;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_r", r, hr);
        check("hold_nv", flag_nv, hnv);
      end
      held = rst_n && out_valid && !out_ready;
      hr   = r;
      hnv  = flag_nv;
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("result_r", r, mon_e.er);
          check("result_nv", flag_nv, mon_e.env);
          if (mon_e.lat) check("latency", cyc - mon_e.cyc, STAGES);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_r", r, 0);
    check("reset_nv", flag_nv, 0);
    check("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Directed vectors with fixed expected values
    send(32'h00000000, 32'h80000000, 3'b000, 32'd1, 1'b0, 1'b1);
    send(32'hBF800000, 32'h3F800000, 3'b001, 32'd1, 1'b0, 1'b1);
    send(32'h7FC00000, 32'h3F800000, 3'b010, 32'd0, 1'b1, 1'b1);
    send(32'h7FC00000, 32'h3F800000, 3'b000, 32'd0, 1'b0, 1'b1);
    send(32'h7F800001, 32'h3F800000, 3'b000, 32'd0, 1'b1, 1'b1);
    send(32'h3F800000, 32'h3F800000, 3'b010, 32'd1, 1'b0, 1'b1);
    send(32'h3F800000, 32'h3F800000, 3'b001, 32'd0, 1'b0, 1'b1);
    send(32'hC0000000, 32'hBF800000, 3'b001, 32'd1, 1'b0, 1'b1);
    send(32'h80000000, 32'h00000000, 3'b001, 32'd0, 1'b0, 1'b1);
    send(32'h3F800000, 32'h3F800000, 3'b011, 32'd0, 1'b0, 1'b1);
    send(32'h7F800001, 32'h7F800001, 3'b111, 32'd0, 1'b0, 1'b1);
`ifdef FP_CMP_MINMAX_EN
    send(32'h00000000, 32'h80000000, 3'b100, 32'h80000000, 1'b0, 1'b1);
    send(32'h7F800001, 32'h40000000, 3'b101, 32'h40000000, 1'b1, 1'b1);
    send(32'h7FC00000, 32'h7FC00000, 3'b100, 32'h7FC00000, 1'b0, 1'b1);
`else
    send(32'h00000000, 32'h80000000, 3'b100, 32'd0, 1'b0, 1'b1);
    send(32'h7F800001, 32'h40000000, 3'b101, 32'd0, 1'b0, 1'b1);
`endif
    idle();
    drain("drain_directed");

    // Back-to-back stream with a 5-cycle consumer stall
    fork
      begin
        repeat (8) send_rand();
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        force_stall = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        force_stall = 1'b0;
      end
    join
    drain("drain_stall");

    // Reset with two operations in flight
    force_stall = 1'b1;
    @(posedge clk);
    send(32'h3F800000, 32'h3F800000, 3'b000, 32'd1, 1'b0, 1'b0);
    send(32'h3F800000, 32'h40000000, 3'b001, 32'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    force_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    repeat (6) @(posedge clk);

    // Random traffic with random backpressure
    random_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send_rand();
      if ($urandom_range(0, 5) == 0) idle();
    end
    idle();
    random_bp = 1'b0;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_compare_pipe.md
FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, mantissa field width; operand width W = 1+EXP_W+MAN_W.
REQ-003 Parameter STAGES, default 2, pipeline depth, legal range 1..4.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  input  1  synchronous, active-low reset.
REQ-006 IN_VALID  input  1  operands and OP_SEL valid this cycle.
REQ-007 IN_READY  output  1  block accepts the operation this cycle.
REQ-008 OP_A  input  W  operand A, IEEE-754 layout {sign, exp, man}.
REQ-009 OP_B  input  W  operand B, same layout.
REQ-010 OP_SEL  input  3  000 FEQ, 001 FLT, 010 FLE, 100 FMIN, 101 FMAX, others reserved.
REQ-011 OUT_VALID  output  1  R and FLAG_NV hold a completed result.
REQ-012 OUT_READY  input  1  consumer takes the result this cycle.
REQ-013 R  output  W  compare result (zero-extended 0/1) or min/max value.
REQ-014 FLAG_NV  output  1  invalid-operation flag for the result on R.

Function
REQ-015 An operation is accepted when IN_VALID && IN_READY; a result is consumed when OUT_VALID && OUT_READY.
REQ-016 Each of the STAGES registers holds a valid bit; a stage loads when empty or when its contents move downstream in the same cycle.
REQ-017 IN_READY is 1 whenever stage 1 is empty or advances this cycle; it is combinational from OUT_READY through the valid chain only.
REQ-018 Latency is exactly STAGES cycles from acceptance to OUT_VALID with OUT_READY held 1; throughput is one operation per cycle.
REQ-019 While OUT_VALID && !OUT_READY, R, FLAG_NV and OUT_VALID are held stable and no accepted operation is lost or duplicated.
REQ-020 Accept and consume in the same cycle with the pipeline full keeps occupancy constant.
REQ-021 NaN: exp all ones and man nonzero; sNaN: NaN with man MSB 0; qNaN: man MSB 1.
REQ-022 +0 and -0 compare equal for FEQ/FLT/FLE.
REQ-023 FEQ: R=1 iff neither operand is NaN and values are equal; FLAG_NV=1 only if either operand is sNaN.
REQ-024 FLT/FLE: R=1 iff neither is NaN and A<B (A<=B); FLAG_NV=1 if either operand is any NaN.
REQ-025 Any NaN operand forces R=0 for FEQ/FLT/FLE.
REQ-026 Ordering uses sign-magnitude comparison: differing signs -> negative smaller unless both zero; same sign -> magnitude order, inverted for negatives.
REQ-027 Reserved OP_SEL codes produce R=0, FLAG_NV=0 with normal latency.

Reset
REQ-028 When RST_N=0 at a rising edge, all stage valid bits, OUT_VALID, R and FLAG_NV clear to 0.
REQ-029 IN_READY is 0 while RST_N=0; in-flight operations at reset are discarded, never emitted.
REQ-030 The first acceptance can occur on the first rising edge with RST_N=1.

Configuration
REQ-031 Macro FP_CMP_MINMAX_EN defined: OP_SEL 100/101 perform FMIN/FMAX.
REQ-032 FMIN/FMAX: both NaN -> canonical qNaN (sign 0, exp all ones, man MSB only); one NaN -> the other operand; -0 treated less than +0; FLAG_NV=1 if either operand is sNaN.
REQ-033 Macro undefined: OP_SEL 100/101 are reserved per REQ-027 and no min/max logic is synthesised.

Verification (EXP_W=8, MAN_W=23, STAGES=2)
REQ-034 FEQ A=0x00000000, B=0x80000000 -> R=1, FLAG_NV=0, OUT_VALID 2 cycles after accept.
REQ-035 FLT A=0xBF800000, B=0x3F800000 -> R=1; FLE A=0x7FC00000, B=0x3F800000 -> R=0, FLAG_NV=1; FEQ with qNaN -> R=0, FLAG_NV=0; FEQ with A=0x7F800001 -> R=0, FLAG_NV=1.
REQ-036 Back-to-back 8 ops, OUT_READY held 0 for 5 cycles mid-stream -> IN_READY drops after 2 queued, all 8 results emitted in order, none lost.
REQ-037 RST_N pulsed low for 1 cycle with 2 ops in flight -> OUT_VALID=0 next cycle, neither result appears.
REQ-038 With FP_CMP_MINMAX_EN: FMIN 0x00000000/0x80000000 -> 0x80000000; FMAX 0x7F800001/0x40000000 -> 0x40000000, FLAG_NV=1; FMIN two qNaNs -> 0x7FC00000. Without: FMIN -> R=0, FLAG_NV=0.
